// File: rtl/mux151_pkg.sv
// Shared FSM encoding and default parameters for the 74HC151 scan controller.
// Both the controller and its dwell counter import this package.
package mux151_pkg;

  localparam int SEL_W_DEF = 3;
  localparam int CHAN_DEF  = 8;
  localparam int DWELL_DEF = 2;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } scan_state_e;

endpackage

// File: rtl/mux151_dwell_cnt.sv
// Settle-time down counter: load with (cycles-1), done is high while the count is zero.
// A SETTLE that loads N-1 therefore lasts exactly N cycles.
module mux151_dwell_cnt
  import mux151_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/mux151_scan_ctrl.sv
// Scan controller for an external 74HC151: steps the select lines over the enabled
// channels, samples Y after a settle time, and presents one frame per scan.
module mux151_scan_ctrl
  import mux151_pkg::*;
#(
  parameter int DATA_SelectPart  = SEL_W_DEF,
  parameter int DATA_Single_Part = CHAN_DEF,
  parameter int DWELL            = DWELL_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        continuous,
  input  logic [DATA_Single_Part-1:0] chan_mask,
  input  logic                        mux_y,
  input  logic                        mux_yf,
  input  logic                        frame_ack,
  output logic                        EN_Part,
  output logic [DATA_SelectPart-1:0]  SelectPart,
  output logic [DATA_Single_Part-1:0] frame_data,
  output logic                        frame_err,
  output logic                        frame_valid,
  output logic                        busy,
  output scan_state_e                 dbg_state
);

  // Handshake: frame_valid rises when a frame is complete and stays high with
  // frame_data/frame_err frozen until the cycle frame_ack is sampled high in DONE;
  // frame_ack at any other time has no effect.

  scan_state_e                 state;
  logic [DATA_Single_Part-1:0] mask_q;
  logic [DATA_SelectPart:0]    first_hit;
  logic [DATA_SelectPart:0]    next_hit;
  logic                        launch;
  logic                        dwell_load;
  logic                        dwell_done;

  // Returns {found, index} of the lowest set bit of m at or above position lo.
  function automatic logic [DATA_SelectPart:0] find_from(
    input logic [DATA_Single_Part-1:0] m,
    input int                          lo
  );
    logic [DATA_SelectPart:0] r;
    r = '0;
    for (int i = DATA_Single_Part - 1; i >= 0; i--) begin
      if (m[i] && (i >= lo)) begin
        r = {1'b1, DATA_SelectPart'(i)};
      end
    end
    return r;
  endfunction

  always_comb begin
    first_hit  = find_from(chan_mask, 0);
    next_hit   = find_from(mask_q, int'(SelectPart) + 1);
    launch     = ((state == S_IDLE) && start) ||
                 ((state == S_DONE) && frame_ack && continuous);
    dwell_load = (launch && first_hit[DATA_SelectPart]) ||
                 ((state == S_SAMPLE) && next_hit[DATA_SelectPart]);
  end

  mux151_dwell_cnt u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (dwell_load),
    .load_val (CNT_W'(DWELL - 1)),
    .done     (dwell_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      mask_q      <= '0;
      EN_Part     <= 1'b1;
      SelectPart  <= '0;
      frame_data  <= '0;
      frame_err   <= 1'b0;
      frame_valid <= 1'b0;
      busy        <= 1'b1 & 1'b0;
    end else if (launch) begin
      // New frame: mask is captured here so later mask changes cannot leak in.
      mask_q     <= chan_mask;
      frame_data <= '0;
      frame_err  <= 1'b0;
      busy       <= 1'b1;
      if (first_hit[DATA_SelectPart]) begin
        state       <= S_SETTLE;
        SelectPart  <= first_hit[DATA_SelectPart-1:0];
        EN_Part     <= 1'b0;
        frame_valid <= 1'b0;
      end else begin
        state       <= S_DONE;
        frame_valid <= 1'b1;
      end
    end else begin
      case (state)
        S_IDLE: begin
        end
        S_SETTLE: begin
          if (dwell_done) begin
            state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          frame_data[SelectPart] <= mux_y;
          if (mux_y == mux_yf) begin
            frame_err <= 1'b1;
          end
          if (next_hit[DATA_SelectPart]) begin
            state      <= S_SETTLE;
            SelectPart <= next_hit[DATA_SelectPart-1:0];
          end else begin
            state       <= S_DONE;
            EN_Part     <= 1'b1;
            frame_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (frame_ack) begin
            state       <= S_IDLE;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule
